// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU run a shift-add multiplier and DIV/DIVU run a restoring divider,
// each producing one result bit per cycle. Both work on magnitudes, and a final
// FIX cycle applies the sign correction. MTHI/MTLO write HI/LO directly from
// IDLE.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   defined   : MULT/MULTU use a single-cycle '*' product (IDLE -> DONE)
//   undefined : iterative multiplier, no multiply operator is synthesised
//
// Ports:
//   clk      in   rising-edge clock
//   rest     in   synchronous active-low reset
//   start    in   request strobe, sampled only while idle
//   op       in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   a, b     in   operands (rs, rt)
//   flush    in   abort a running operation
//   busy     out  iterative operation in progress
//   done     out  one-cycle pulse when HI/LO take a mul/div result
//   div_zero out  pulse with done when the divisor was zero
//   hi, lo   out  HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Two's-complement negation helpers.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_2W;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_p_hi;      // mul: running upper product; div: remainder
    logic [WIDTH-1:0]   r_p_lo;      // mul: multiplier/lower product; div: dividend/quotient
    logic [WIDTH-1:0]   r_b;         // multiplicand or divisor magnitude
    logic               r_neg_q;     // negate product / quotient
    logic               r_neg_r;     // negate remainder (dividend was negative)
    logic               r_dz;        // divide by zero recorded at start
    logic               r_is_div;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed_op;
    logic               w_b_zero;
    logic               w_sign_diff;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_a;
    logic [2*WIDTH-1:0] w_fast_b;
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    // Operand conditioning: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        w_signed_op = (op == OP_MULT) || (op == OP_DIV);
        w_b_zero    = (b == {WIDTH{1'b0}});
        w_sign_diff = w_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
        if (w_signed_op && a[WIDTH-1]) begin
            w_abs_a = neg_w(a);
        end else begin
            w_abs_a = a;
        end
        if (w_signed_op && b[WIDTH-1]) begin
            w_abs_b = neg_w(b);
        end else begin
            w_abs_b = b;
        end
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        if (r_p_lo[0]) begin
            w_mul_sum = {1'b0, r_p_hi} + {1'b0, r_b};
        end else begin
            w_mul_sum = {1'b0, r_p_hi};
        end
        // Remainder stays below the divisor, so bit WIDTH of the difference
        // is set exactly when the trial subtraction borrows.
        w_div_shift = {r_p_hi, r_p_lo[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
    end

    // Sign correction applied in the FIX cycle.
    always_comb begin
        if (r_neg_q) begin
            w_prod_fix = neg_2w({r_p_hi, r_p_lo});
            w_quo_fix  = neg_w(r_p_lo);
        end else begin
            w_prod_fix = {r_p_hi, r_p_lo};
            w_quo_fix  = r_p_lo;
        end
        if (r_neg_r) begin
            w_rem_fix = neg_w(r_p_hi);
        end else begin
            w_rem_fix = r_p_hi;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product: sign- or zero-extend to 2*WIDTH, keep the low half.
    always_comb begin
        if (op == OP_MULT) begin
            w_fast_a = {{WIDTH{a[WIDTH-1]}}, a};
            w_fast_b = {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            w_fast_a = {{WIDTH{1'b0}}, a};
            w_fast_b = {{WIDTH{1'b0}}, b};
        end
        w_fast_prod = w_fast_a * w_fast_b;
    end
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rest) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_p_hi     <= {WIDTH{1'b0}};
            r_p_lo     <= {WIDTH{1'b0}};
            r_b        <= {WIDTH{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_is_div   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= {WIDTH{1'b0}};
            r_lo       <= {WIDTH{1'b0}};
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                                r_hi    <= w_fast_prod[2*WIDTH-1:WIDTH];
                                r_lo    <= w_fast_prod[WIDTH-1:0];
                                r_busy  <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
`else
                                r_p_hi   <= {WIDTH{1'b0}};
                                r_p_lo   <= w_abs_a;
                                r_b      <= w_abs_b;
                                r_neg_q  <= w_sign_diff;
                                r_neg_r  <= 1'b0;
                                r_dz     <= 1'b0;
                                r_is_div <= 1'b0;
                                r_cnt    <= {CNT_W{1'b0}};
                                r_busy   <= 1'b1;
                                r_state  <= S_MUL;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                r_p_hi   <= {WIDTH{1'b0}};
                                // With a zero divisor the raw dividend is kept for HI.
                                r_p_lo   <= w_b_zero ? a : w_abs_a;
                                r_b      <= w_abs_b;
                                r_neg_q  <= w_sign_diff;
                                r_neg_r  <= w_signed_op && a[WIDTH-1];
                                r_dz     <= w_b_zero;
                                r_is_div <= 1'b1;
                                r_cnt    <= {CNT_W{1'b0}};
                                r_busy   <= 1'b1;
                                r_state  <= S_DIV;
                            end
                            default: ;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_p_hi <= w_mul_sum[WIDTH:1];
                        r_p_lo <= {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
                        r_cnt  <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_dz) begin
                        r_state <= S_FIX;
                    end else begin
                        if (w_div_diff[WIDTH]) begin
                            r_p_hi <= w_div_shift[WIDTH-1:0];
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b0};
                        end else begin
                            r_p_hi <= w_div_diff[WIDTH-1:0];
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b1};
                        end
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_DIV;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (!r_is_div) begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end else if (r_dz) begin
                            r_hi <= r_p_lo;
                            r_lo <= {WIDTH{1'b1}};
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end
                        r_done     <= 1'b1;
                        r_div_zero <= r_is_div && r_dz;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
